// File: rtl/ce_window_gen.sv
// ce_window_gen: streaming KERNELxKERNEL sliding-window generator for the CE
// convolution engine. Pixels arrive in raster order, one per enabled cycle.
// KERNEL-1 line buffers hold the previous rows. Every fully populated window is
// emitted on data2conv with a one-cycle en_out pulse.
module ce_window_gen #(
    parameter int CL_IN  = 1,
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CL_IN*N-1:0]                 pix_in,
    input  logic                               pix_en,
    output logic [CL_IN*KERNEL*KERNEL*N-1:0]   data2conv,
    output logic                               en_out,
    output logic                               frame_end
);

    localparam int K2    = KERNEL * KERNEL;
    localparam int WIN_W = CL_IN * K2 * N;
    localparam int PIX_W = CL_IN * N;
    localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB    = (KERNEL > 1) ? KERNEL - 1 : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL - 1);

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             en_q, en_d;
    logic             fe_q, fe_d;

    // new_col[r] is the pixel that enters window row r at the current column;
    // the bottom row takes the live pixel, the others come from the line buffers.
    logic [PIX_W-1:0] new_col [KERNEL];
    logic [PIX_W-1:0] line_buf_q [LB][IMG_W];

    // Gather the incoming window column from the line buffers and the live pixel.
    always_comb begin
        for (int r = 0; r < KERNEL; r++) begin
            new_col[r] = pix_in;
        end
        for (int r = 0; r < KERNEL - 1; r++) begin
            new_col[r] = line_buf_q[r][col_q];
        end
    end

    // Raster position tracking and window-valid / frame-end decode for each accepted pixel.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        en_d  = 1'b0;
        fe_d  = 1'b0;
        if (pix_en) begin
            en_d = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
            fe_d = en_d && (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Shift every window row left by one column and append the new column on the right.
    always_comb begin
        win_d = win_q;
        if (pix_en) begin
            for (int c = 0; c < CL_IN; c++) begin
                for (int r = 0; r < KERNEL; r++) begin
                    for (int k = 0; k < KERNEL; k++) begin
                        if (k < KERNEL - 1) begin
                            win_d[(c*K2 + r*KERNEL + k)*N +: N] =
                                win_q[(c*K2 + r*KERNEL + k + 1)*N +: N];
                        end else begin
                            win_d[(c*K2 + r*KERNEL + k)*N +: N] = new_col[r][c*N +: N];
                        end
                    end
                end
            end
        end
    end

    // State registers; a reset drops any pending output and restarts at row 0, col 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            win_q <= '0;
            en_q  <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
            en_q  <= en_d;
            fe_q  <= fe_d;
        end
    end

    generate
        if (KERNEL > 1) begin : g_line_buf
            // Line buffers are plain RAM; each row ages by one buffer per accepted pixel.
            always_ff @(posedge clk) begin
                if (!rst && pix_en) begin
                    for (int j = 0; j < KERNEL - 1; j++) begin
                        line_buf_q[j][col_q] <= new_col[j+1];
                    end
                end
            end
        end
    endgenerate

    assign data2conv = win_q;
    assign en_out    = en_q;
    assign frame_end = fe_q;

endmodule
